stop_watch_pro: RTL and testbench
=================================

STOP_WATCH_PRO -- requirements
Module: stop_watch_pro

Interface
REQ-001 SHALL provide parameter TICK_DIV, default 1: clock cycles per one-second tick; legal range 1..2^24.
REQ-002 SHALL provide parameter HR_MAX, default 23: highest hour value before wrap; legal range 1..99.
REQ-003 SHALL provide port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL provide port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL provide port start_stop, input, 1 bit: run/stop toggle request, rising-edge detected.
REQ-006 SHALL provide port clear, input, 1 bit: zero the count, level-sampled.
REQ-007 SHALL provide port dir, input, 1 bit: count direction; 0 = up, 1 = down.
REQ-008 SHALL provide port load, input, 1 bit: preload strobe.
REQ-009 SHALL provide port load_val, input, 24 bits: packed BCD {hr_h,hr_l,min_h,min_l,sec_h,sec_l}.
REQ-010 SHALL provide port lap, input, 1 bit: lap capture strobe.
REQ-011 SHALL provide ports hr_h, hr_l, min_h, min_l, sec_h, sec_l, output, 4 bits each: BCD count digits.
REQ-012 SHALL provide port running, output, 1 bit: count enabled.
REQ-013 SHALL provide ports wrap, done and load_err, output, 1 bit each: single-cycle event pulses.
REQ-014 SHALL provide ports lap_val, output, 24 bits, and lap_valid, output, 1 bit: captured lap time and its capture pulse.

Function
REQ-015 SHALL toggle running one cycle after a 0->1 transition of start_stop; a held-high level SHALL toggle running only once.
REQ-016 SHALL advance a prescaler 0..TICK_DIV-1 only while running; tick SHALL assert when the prescaler equals TICK_DIV-1, and the prescaler SHALL then return to 0.
REQ-017 SHALL hold the prescaler and all digits while stopped.
REQ-018 Up mode on tick: sec_l 0..9 -> sec_h 0..5 -> min_l 0..9 -> min_h 0..5 -> hours 00..HR_MAX, with the carry rippling within the same cycle.
REQ-019 Up mode at HR_MAX:59:59 on tick SHALL go to 00:00:00, pulse wrap for one cycle, and keep running.
REQ-020 Down mode on tick SHALL decrement with borrow (sec 00 -> 59, min 00 -> 59).
REQ-021 Down mode: on the tick that produces 00:00:00, done SHALL pulse and running SHALL clear in the same cycle.
REQ-022 Down mode ticking from 00:00:00 SHALL pulse done and clear running, with the digits left unchanged.
REQ-023 A dir change SHALL take effect on the next tick; the prescaler SHALL NOT be reset by it.
REQ-024 load while stopped SHALL copy load_val into the digits when every digit is legal; legal means sec_h and min_h <= 5, all digits <= 9, and hours <= HR_MAX.
REQ-025 An illegal load_val SHALL leave the digits unchanged and pulse load_err for one cycle.
REQ-026 load while running SHALL be ignored, without a load_err pulse.
REQ-027 clear SHALL zero the digits and the prescaler; running SHALL be unchanged.
REQ-028 Priority SHALL be clear > load > tick; a start_stop edge coinciding with clear SHALL still toggle running.
REQ-029 Digit outputs SHALL be registered: a value change is visible the cycle after its cause.

Reset
REQ-030 rst SHALL force all digits to 0, prescaler to 0, running to 0, the edge-detect register to 0, wrap/done/load_err/lap_valid to 0 and lap_val to 0.
REQ-031 rst SHALL override every other input in the same cycle, including mid-count and mid-load.

Configuration
REQ-032 Macro STOP_WATCH_LAP_CAPTURE_EN defined: lap high while running SHALL copy the current (pre-tick) digits into lap_val and pulse lap_valid next cycle.
REQ-033 With STOP_WATCH_LAP_CAPTURE_EN defined, lap while stopped SHALL be ignored, and lap_val SHALL hold until the next capture or rst.
REQ-034 Macro STOP_WATCH_LAP_CAPTURE_EN undefined: lap SHALL be ignored, lap_val SHALL be constant 0 and lap_valid constant 0, with no capture register synthesised.

Verification
REQ-035 TICK_DIV=1: rst 2 cycles, 1-cycle start_stop, 3600 cycles -> 01:00:00; 1-cycle start_stop -> running=0 and the digits hold.
REQ-036 Load 0x235959, dir=0, start -> next tick gives 00:00:00, wrap=1 for one cycle, and running stays 1.
REQ-037 Load 0x000003, dir=1, start -> 02, 01, 00 on successive ticks; done pulses with 00, running=0, and the digits stay 0.
REQ-038 Load 0x006000 -> load_err pulse, digits unchanged; load 0x000100 while running -> ignored, no load_err.
REQ-039 TICK_DIV=4: sec_l increments every 4th cycle; clear at 00:00:07 while running -> 00:00:00, running=1, and the next increment 4 cycles after clear.
REQ-040 Macro defined: lap at 00:00:10 -> lap_val=0x000010 and lap_valid for one cycle; macro undefined -> lap_val=0 and lap_valid=0 throughout.

Source files
------------

// File: rtl/stop_watch_pro.sv
// stop_watch_pro
//   BCD hh:mm:ss stopwatch / countdown timer. The count runs up (with wrap at
//   HR_MAX:59:59) or down (stopping itself at 00:00:00). A prescaler turns
//   TICK_DIV clock cycles into one one-second tick. Digits can be preloaded
//   while stopped, and they are range-checked before they are accepted.
//
//   Optional feature, enabled by defining STOP_WATCH_LAP_CAPTURE_EN:
//     lap capture. While running, a high lap input copies the current digits
//     into lap_val and raises lap_valid for one cycle.
//
//   Handshake: lap_valid is a valid-only strobe (there is no ready). It is
//   high for exactly one cycle per capture. lap_val stays stable from that
//   cycle until the next capture or reset, so a consumer may sample it late.
//
//   Priority of the digit update inside one cycle: clear > load > tick.
//   A start_stop rising edge still toggles running in a clear cycle.
module stop_watch_pro #(
    parameter int TICK_DIV = 1,
    parameter int HR_MAX   = 23
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        dir,
    input  logic        load,
    input  logic [23:0] load_val,
    input  logic        lap,
    output logic [3:0]  hr_h,
    output logic [3:0]  hr_l,
    output logic [3:0]  min_h,
    output logic [3:0]  min_l,
    output logic [3:0]  sec_h,
    output logic [3:0]  sec_l,
    output logic        running,
    output logic        wrap,
    output logic        done,
    output logic        load_err,
    output logic [23:0] lap_val,
    output logic        lap_valid
);

    // A prescaler of width 1 still works for TICK_DIV = 1: it stays at 0,
    // which equals the last value, so every running cycle is a tick.
    localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0]     HR_MAX_H   = 4'(HR_MAX / 10);
    localparam logic [3:0]     HR_MAX_L   = 4'(HR_MAX % 10);
    localparam logic [7:0]     HR_MAX_V   = 8'(HR_MAX);

    // Count register, packed as {hr_h,hr_l,min_h,min_l,sec_h,sec_l}.
    logic [23:0]   cnt;
    logic [23:0]   cnt_d;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_d;
    logic          running_d;
    logic          ss_q;
    logic          wrap_d;
    logic          done_d;
    logic          load_err_d;

    // Digit views of the current count.
    logic [3:0] c_hr_h;
    logic [3:0] c_hr_l;
    logic [3:0] c_min_h;
    logic [3:0] c_min_l;
    logic [3:0] c_sec_h;
    logic [3:0] c_sec_l;

    assign c_hr_h  = cnt[23:20];
    assign c_hr_l  = cnt[19:16];
    assign c_min_h = cnt[15:12];
    assign c_min_l = cnt[11:8];
    assign c_sec_h = cnt[7:4];
    assign c_sec_l = cnt[3:0];

    assign hr_h  = c_hr_h;
    assign hr_l  = c_hr_l;
    assign min_h = c_min_h;
    assign min_l = c_min_l;
    assign sec_h = c_sec_h;
    assign sec_l = c_sec_l;

    logic start_edge;
    logic tick;
    logic hr_at_max;
    logic cur_zero;

    assign start_edge = start_stop & ~ss_q;
    assign tick       = running && (presc == PRESC_LAST);
    assign hr_at_max  = (c_hr_h == HR_MAX_H) && (c_hr_l == HR_MAX_L);
    assign cur_zero   = (cnt == 24'h000000);

    // Legality of the preload value: BCD digits, tens of min/sec at most 5,
    // and an hour value not above HR_MAX.
    logic       load_ok;
    logic [7:0] load_hr;

    always_comb begin
        load_hr = ({4'd0, load_val[23:20]} * 8'd10) + {4'd0, load_val[19:16]};
        load_ok = (load_val[23:20] <= 4'd9) && (load_val[19:16] <= 4'd9) &&
                  (load_val[15:12] <= 4'd5) && (load_val[11:8]  <= 4'd9) &&
                  (load_val[7:4]   <= 4'd5) && (load_val[3:0]   <= 4'd9) &&
                  (load_hr <= HR_MAX_V);
    end

    // Up-count successor: ripple carry from sec_l through the hours.
    logic [23:0] up_cnt;
    logic        up_wrap;

    always_comb begin
        up_cnt  = cnt;
        up_wrap = 1'b0;
        if (c_sec_l != 4'd9) begin
            up_cnt[3:0] = c_sec_l + 4'd1;
        end else begin
            up_cnt[3:0] = 4'd0;
            if (c_sec_h != 4'd5) begin
                up_cnt[7:4] = c_sec_h + 4'd1;
            end else begin
                up_cnt[7:4] = 4'd0;
                if (c_min_l != 4'd9) begin
                    up_cnt[11:8] = c_min_l + 4'd1;
                end else begin
                    up_cnt[11:8] = 4'd0;
                    if (c_min_h != 4'd5) begin
                        up_cnt[15:12] = c_min_h + 4'd1;
                    end else begin
                        up_cnt[15:12] = 4'd0;
                        if (hr_at_max) begin
                            up_cnt[23:16] = 8'h00;
                            up_wrap       = 1'b1;
                        end else if (c_hr_l != 4'd9) begin
                            up_cnt[19:16] = c_hr_l + 4'd1;
                        end else begin
                            up_cnt[19:16] = 4'd0;
                            up_cnt[23:20] = c_hr_h + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // Down-count predecessor: ripple borrow. Only used when the count is
    // non-zero, so the hours never need to borrow below 00.
    logic [23:0] dn_cnt;
    logic        dn_zero;

    always_comb begin
        dn_cnt = cnt;
        if (c_sec_l != 4'd0) begin
            dn_cnt[3:0] = c_sec_l - 4'd1;
        end else begin
            dn_cnt[3:0] = 4'd9;
            if (c_sec_h != 4'd0) begin
                dn_cnt[7:4] = c_sec_h - 4'd1;
            end else begin
                dn_cnt[7:4] = 4'd5;
                if (c_min_l != 4'd0) begin
                    dn_cnt[11:8] = c_min_l - 4'd1;
                end else begin
                    dn_cnt[11:8] = 4'd9;
                    if (c_min_h != 4'd0) begin
                        dn_cnt[15:12] = c_min_h - 4'd1;
                    end else begin
                        dn_cnt[15:12] = 4'd5;
                        if (c_hr_l != 4'd0) begin
                            dn_cnt[19:16] = c_hr_l - 4'd1;
                        end else begin
                            dn_cnt[19:16] = 4'd9;
                            dn_cnt[23:20] = c_hr_h - 4'd1;
                        end
                    end
                end
            end
        end
        dn_zero = (dn_cnt == 24'h000000);
    end

    // Next-state selection: prescaler, run flag, digits and event pulses.
    always_comb begin
        cnt_d      = cnt;
        presc_d    = presc;
        running_d  = running ^ start_edge;
        wrap_d     = 1'b0;
        done_d     = 1'b0;
        load_err_d = 1'b0;

        if (running) begin
            presc_d = tick ? '0 : presc + PW'(1);
        end

        if (clear) begin
            cnt_d   = 24'h000000;
            presc_d = '0;
        end else if (load && !running) begin
            if (load_ok) begin
                cnt_d = load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (tick) begin
            if (!dir) begin
                cnt_d  = up_cnt;
                wrap_d = up_wrap;
            end else if (cur_zero) begin
                // Already at zero: report done, leave the digits alone.
                done_d    = 1'b1;
                running_d = 1'b0;
            end else begin
                cnt_d = dn_cnt;
                if (dn_zero) begin
                    done_d    = 1'b1;
                    running_d = 1'b0;
                end
            end
        end
    end

    // State and pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 24'h000000;
            presc    <= '0;
            running  <= 1'b0;
            ss_q     <= 1'b0;
            wrap     <= 1'b0;
            done     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            cnt      <= cnt_d;
            presc    <= presc_d;
            running  <= running_d;
            ss_q     <= start_stop;
            wrap     <= wrap_d;
            done     <= done_d;
            load_err <= load_err_d;
        end
    end

`ifdef STOP_WATCH_LAP_CAPTURE_EN
    // Lap capture: snapshot the pre-tick digits while running.
    always_ff @(posedge clk) begin
        if (rst) begin
            lap_val   <= 24'h000000;
            lap_valid <= 1'b0;
        end else begin
            lap_valid <= running & lap;
            if (running && lap) begin
                lap_val <= cnt;
            end
        end
    end
`else
    logic unused_lap;

    assign unused_lap = lap;
    assign lap_val    = 24'h000000;
    assign lap_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_stop_watch_pro.sv
// tb_stop_watch_pro
//   Two instances (TICK_DIV = 1 and TICK_DIV = 4) share one set of inputs.
//   A seconds-based reference model predicts every output of both each cycle;
//   a directed table and hand sequences add fixed expected values.
module tb_stop_watch_pro;

    localparam int HR_MAX = 23;
    localparam int TOTAL  = (HR_MAX + 1) * 3600;
`ifdef STOP_WATCH_LAP_CAPTURE_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start_stop = 1'b0;
    logic        clear = 1'b0;
    logic        dir = 1'b0;
    logic        load = 1'b0;
    logic [23:0] load_val = 24'h0;
    logic        lap = 1'b0;

    logic [3:0]  a_hr_h, a_hr_l, a_min_h, a_min_l, a_sec_h, a_sec_l;
    logic        a_running, a_wrap, a_done, a_load_err, a_lap_valid;
    logic [23:0] a_lap_val;
    logic [3:0]  b_hr_h, b_hr_l, b_min_h, b_min_l, b_sec_h, b_sec_l;
    logic        b_running, b_wrap, b_done, b_load_err, b_lap_valid;
    logic [23:0] b_lap_val;

    stop_watch_pro #(.TICK_DIV(1), .HR_MAX(HR_MAX)) dut_a (
        .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .dir(dir),
        .load(load), .load_val(load_val), .lap(lap),
        .hr_h(a_hr_h), .hr_l(a_hr_l), .min_h(a_min_h), .min_l(a_min_l),
        .sec_h(a_sec_h), .sec_l(a_sec_l), .running(a_running), .wrap(a_wrap),
        .done(a_done), .load_err(a_load_err), .lap_val(a_lap_val), .lap_valid(a_lap_valid)
    );

    stop_watch_pro #(.TICK_DIV(4), .HR_MAX(HR_MAX)) dut_b (
        .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .dir(dir),
        .load(load), .load_val(load_val), .lap(lap),
        .hr_h(b_hr_h), .hr_l(b_hr_l), .min_h(b_min_h), .min_l(b_min_l),
        .sec_h(b_sec_h), .sec_l(b_sec_l), .running(b_running), .wrap(b_wrap),
        .done(b_done), .load_err(b_load_err), .lap_val(b_lap_val), .lap_valid(b_lap_valid)
    );

    logic [23:0] a_cnt, b_cnt;
    assign a_cnt = {a_hr_h, a_hr_l, a_min_h, a_min_l, a_sec_h, a_sec_l};
    assign b_cnt = {b_hr_h, b_hr_l, b_min_h, b_min_l, b_sec_h, b_sec_l};

    // Observation vector: {digits, running, wrap, done, load_err, lap_valid, lap_val}
    logic [52:0] obs [2];
    assign obs[0] = {a_cnt, a_running, a_wrap, a_done, a_load_err, a_lap_valid, a_lap_val};
    assign obs[1] = {b_cnt, b_running, b_wrap, b_done, b_load_err, b_lap_valid, b_lap_val};

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [52:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model (time kept as plain seconds) ----------------
    int          td [2] = '{1, 4};
    int          m_secs [2];
    int          m_presc [2];
    bit          m_run [2];
    bit          m_ssq [2];
    bit          m_wrap [2];
    bit          m_done [2];
    bit          m_err [2];
    bit          m_lapv [2];
    logic [23:0] m_lap [2];

    function automatic logic [23:0] to_bcd(input int s);
        int h, m, c;
        h = s / 3600;
        m = (s / 60) % 60;
        c = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    function automatic int dig(input logic [23:0] v, input int k);
        return int'((v >> (4 * k)) & 24'hF);
    endfunction

    function automatic bit bcd_legal(input logic [23:0] v);
        for (int k = 0; k < 6; k++) if (dig(v, k) > 9) return 1'b0;
        if (dig(v, 1) > 5 || dig(v, 3) > 5) return 1'b0;
        return (dig(v, 5) * 10 + dig(v, 4)) <= HR_MAX;
    endfunction

    function automatic int from_bcd(input logic [23:0] v);
        return (dig(v, 5) * 10 + dig(v, 4)) * 3600 + (dig(v, 3) * 10 + dig(v, 2)) * 60 +
               dig(v, 1) * 10 + dig(v, 0);
    endfunction

    function automatic void model_step(input int i);
        bit edge_s, tick_s, nrun;
        int nsecs, npresc;
        if (rst) begin
            m_secs[i] = 0; m_presc[i] = 0; m_run[i] = 0; m_ssq[i] = 0;
            m_wrap[i] = 0; m_done[i] = 0; m_err[i] = 0; m_lapv[i] = 0; m_lap[i] = 24'h0;
            return;
        end
        edge_s = start_stop && !m_ssq[i];
        tick_s = m_run[i] && (m_presc[i] == td[i] - 1);
        nrun   = m_run[i] ^ edge_s;
        npresc = m_run[i] ? (tick_s ? 0 : m_presc[i] + 1) : m_presc[i];
        nsecs  = m_secs[i];
        m_wrap[i] = 0; m_done[i] = 0; m_err[i] = 0;
        if (clear) begin
            nsecs = 0; npresc = 0;
        end else if (load && !m_run[i]) begin
            if (bcd_legal(load_val)) nsecs = from_bcd(load_val);
            else m_err[i] = 1;
        end else if (tick_s) begin
            if (!dir) begin
                nsecs = (m_secs[i] + 1) % TOTAL;
                m_wrap[i] = (nsecs == 0);
            end else if (m_secs[i] == 0) begin
                m_done[i] = 1; nrun = 0;
            end else begin
                nsecs = m_secs[i] - 1;
                if (nsecs == 0) begin m_done[i] = 1; nrun = 0; end
            end
        end
        if (LAP_EN && m_run[i] && lap) begin
            m_lap[i] = to_bcd(m_secs[i]);
            m_lapv[i] = 1;
        end else begin
            m_lapv[i] = 0;
        end
        m_secs[i] = nsecs; m_presc[i] = npresc; m_run[i] = nrun; m_ssq[i] = start_stop;
    endfunction

    function automatic logic [52:0] model_obs(input int i);
        return {to_bcd(m_secs[i]), m_run[i], m_wrap[i], m_done[i], m_err[i], m_lapv[i], m_lap[i]};
    endfunction

    // ---------------- driver: one clock, then model + compare ----------------
    task automatic tick_clk();
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i);
        for (int i = 0; i < 2; i++) exp_q.push_back(model_obs(i));
        #1;
        for (int i = 0; i < 2; i++) begin
            logic [52:0] e;
            e = exp_q.pop_front();
            if (i == 0) check("cycle_dut_a", 64'(obs[0]), 64'(e));
            else        check("cycle_dut_b", 64'(obs[1]), 64'(e));
        end
    endtask

    task automatic set_in(input logic s, input logic c, input logic l, input logic d,
                          input logic [23:0] v);
        start_stop = s; clear = c; load = l; dir = d; load_val = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 24'h0);
        lap = 1'b0;
        tick_clk();
        rst = 1'b0;
    endtask

    // ---------------- directed table (dut_a, TICK_DIV = 1) ----------------
    typedef struct {
        logic        ss, clr, ld, dr;
        logic [23:0] lv;
        logic [23:0] e_cnt;
        logic        e_run, e_wrap, e_done, e_err;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input logic ss, input logic clr, input logic ld, input logic dr,
                       input logic [23:0] lv, input logic [23:0] e_cnt, input logic e_run,
                       input logic e_wrap, input logic e_done, input logic e_err);
        vec_t v;
        v.ss = ss; v.clr = clr; v.ld = ld; v.dr = dr; v.lv = lv;
        v.e_cnt = e_cnt; v.e_run = e_run; v.e_wrap = e_wrap; v.e_done = e_done; v.e_err = e_err;
        tbl.push_back(v);
    endtask

    function automatic logic [23:0] rand_load();
        case ($urandom_range(0, 3))
            0: return to_bcd(int'($urandom_range(0, TOTAL - 1)));
            1: return to_bcd(TOTAL - 1 - int'($urandom_range(0, 2)));
            2: return to_bcd(int'($urandom_range(0, 3)));
            default: return 24'($urandom);
        endcase
    endfunction

    initial begin
        //   ss clr ld dir load_val   exp_cnt    run wrap done err
        add(0, 1, 0, 0, 24'h000000, 24'h000000, 0, 0, 0, 0);
        add(0, 0, 1, 0, 24'h235959, 24'h235959, 0, 0, 0, 0);
        add(0, 0, 1, 0, 24'h006000, 24'h235959, 0, 0, 0, 1);
        add(0, 0, 0, 0, 24'h000000, 24'h235959, 0, 0, 0, 0);
        add(0, 0, 1, 0, 24'h240000, 24'h235959, 0, 0, 0, 1);
        add(0, 0, 1, 0, 24'h00005A, 24'h235959, 0, 0, 0, 1);
        add(0, 0, 1, 0, 24'h000003, 24'h000003, 0, 0, 0, 0);
        add(0, 0, 1, 0, 24'h123456, 24'h123456, 0, 0, 0, 0);
        add(0, 1, 1, 0, 24'h999999, 24'h000000, 0, 0, 0, 0);
        add(0, 0, 1, 0, 24'h235959, 24'h235959, 0, 0, 0, 0);
        add(1, 0, 0, 0, 24'h000000, 24'h235959, 1, 0, 0, 0);
        add(0, 0, 0, 0, 24'h000000, 24'h000000, 1, 1, 0, 0);
        add(0, 0, 0, 0, 24'h000000, 24'h000001, 1, 0, 0, 0);
        add(0, 0, 1, 0, 24'h000100, 24'h000002, 1, 0, 0, 0);
        add(1, 0, 0, 0, 24'h000000, 24'h000003, 0, 0, 0, 0);
        add(0, 0, 0, 0, 24'h000000, 24'h000003, 0, 0, 0, 0);
        add(1, 0, 0, 1, 24'h000000, 24'h000003, 1, 0, 0, 0);
        add(0, 0, 0, 1, 24'h000000, 24'h000002, 1, 0, 0, 0);
        add(0, 0, 0, 1, 24'h000000, 24'h000001, 1, 0, 0, 0);
        add(0, 0, 0, 1, 24'h000000, 24'h000000, 0, 0, 1, 0);
        add(0, 0, 0, 1, 24'h000000, 24'h000000, 0, 0, 0, 0);
        add(1, 0, 0, 1, 24'h000000, 24'h000000, 1, 0, 0, 0);
        add(0, 0, 0, 1, 24'h000000, 24'h000000, 0, 0, 1, 0);
        add(0, 0, 1, 0, 24'h000507, 24'h000507, 0, 0, 0, 0);
        add(1, 0, 0, 0, 24'h000000, 24'h000507, 1, 0, 0, 0);
        add(0, 0, 0, 0, 24'h000000, 24'h000508, 1, 0, 0, 0);
        add(0, 1, 0, 0, 24'h000000, 24'h000000, 1, 0, 0, 0);
        add(1, 1, 0, 0, 24'h000000, 24'h000000, 0, 0, 0, 0);
        add(0, 0, 0, 0, 24'h000000, 24'h000000, 0, 0, 0, 0);

        // Reset (two cycles) and reset state.
        do_reset();
        rst = 1'b1;
        tick_clk();
        rst = 1'b0;
        check("reset_state_a", 64'(obs[0]), 64'd0);
        check("reset_state_b", 64'(obs[1]), 64'd0);

        // One hour at one tick per cycle, then stop and hold.
        set_in(1, 0, 0, 0, 24'h0);
        tick_clk();
        set_in(0, 0, 0, 0, 24'h0);
        for (int k = 0; k < 3600; k++) tick_clk();
        check("one_hour_digits", 64'(a_cnt), 64'(24'h010000));
        check("one_hour_running", 64'(a_running), 64'd1);
        set_in(1, 0, 0, 0, 24'h0);
        tick_clk();
        set_in(0, 0, 0, 0, 24'h0);
        check("stop_running", 64'(a_running), 64'd0);
        for (int k = 0; k < 5; k++) begin
            tick_clk();
            check("stop_hold", 64'({a_cnt, a_running}), 64'({24'h010001, 1'b0}));
        end

        // Table of directed vectors.
        for (int r = 0; r < tbl.size(); r++) begin
            set_in(tbl[r].ss, tbl[r].clr, tbl[r].ld, tbl[r].dr, tbl[r].lv);
            tick_clk();
            check($sformatf("tbl_row_%0d", r),
                  64'({a_cnt, a_running, a_wrap, a_done, a_load_err}),
                  64'({tbl[r].e_cnt, tbl[r].e_run, tbl[r].e_wrap, tbl[r].e_done, tbl[r].e_err}));
        end

        // Prescaler of 4 on dut_b: every 4th cycle, clear at 00:00:07.
        do_reset();
        set_in(1, 0, 0, 0, 24'h0);
        tick_clk();
        set_in(0, 0, 0, 0, 24'h0);
        for (int k = 1; k <= 28; k++) begin
            tick_clk();
            check($sformatf("div4_count_%0d", k), 64'(b_cnt), 64'(k / 4));
        end
        set_in(0, 1, 0, 0, 24'h0);
        tick_clk();
        set_in(0, 0, 0, 0, 24'h0);
        check("div4_clear", 64'({b_cnt, b_running}), 64'({24'h000000, 1'b1}));
        for (int k = 1; k <= 4; k++) begin
            tick_clk();
            check($sformatf("div4_after_clear_%0d", k), 64'(b_cnt), 64'((k == 4) ? 1 : 0));
        end

        // Lap capture at 00:00:10 on dut_a.
        do_reset();
        set_in(1, 0, 0, 0, 24'h0);
        tick_clk();
        set_in(0, 0, 0, 0, 24'h0);
        for (int k = 0; k < 10; k++) tick_clk();
        check("lap_pre_digits", 64'(a_cnt), 64'(24'h000010));
        lap = 1'b1;
        tick_clk();
        lap = 1'b0;
        check("lap_capture", 64'({a_lap_val, a_lap_valid}),
              LAP_EN ? 64'({24'h000010, 1'b1}) : 64'd0);
        tick_clk();
        check("lap_pulse_end", 64'({a_lap_val, a_lap_valid}),
              LAP_EN ? 64'({24'h000010, 1'b0}) : 64'd0);
        set_in(1, 0, 0, 0, 24'h0);
        tick_clk();
        set_in(0, 0, 0, 0, 24'h0);
        lap = 1'b1;
        tick_clk();
        lap = 1'b0;
        check("lap_stopped_ignored", 64'({a_lap_val, a_lap_valid}),
              LAP_EN ? 64'({24'h000010, 1'b0}) : 64'd0);

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            rst        = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 11) == 0) start_stop = ~start_stop;
            clear      = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 39) == 0) dir = ~dir;
            load       = ($urandom_range(0, 9) == 0);
            load_val   = rand_load();
            lap        = ($urandom_range(0, 7) == 0);
            tick_clk();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
